// File: rtl/cms_pkg.sv
// Shared definitions for the CMS packer/unpacker datapath: FSM encoding,
// command codes and the reference clock period.
package cms_pkg;

  localparam int CLK_PERIOD = 10;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_SHIFT = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  localparam logic [2:0] CMD_NOP       = 3'd0;
  localparam logic [2:0] CMD_WRITE_DAT = 3'd1;
  localparam logic [2:0] CMD_READ_DAT  = 3'd2;
  localparam logic [2:0] CMD_WRITE_REG = 3'd3;
  localparam logic [2:0] CMD_READ_REG  = 3'd4;
  localparam logic [2:0] CMD_RESET     = 3'd5;

  // Bytes carried by the next word: a full word unless fewer remain.
  function automatic logic [2:0] word_bytes(input logic [7:0] remaining);
    return (remaining >= 8'd4) ? 3'd4 : remaining[2:0];
  endfunction

endpackage

// File: rtl/cms_unpackage_if.sv
// Word-FIFO read port and card-side byte stream of the CMS unpacker.
interface cms_unpackage_if;

  logic [31:0] fifo_dout_i;
  logic        fifo_empty_i;
  logic        fifo_rd_en_o;
  logic [7:0]  data_o;
  logic        data_valid_o;
  logic        data_ready_i;

  modport master (
    output fifo_rd_en_o, data_o, data_valid_o,
    input  fifo_dout_i, fifo_empty_i, data_ready_i
  );

  modport slave (
    input  fifo_rd_en_o, data_o, data_valid_o,
    output fifo_dout_i, fifo_empty_i, data_ready_i
  );

endinterface

// File: rtl/cms_word_shifter.sv
// Holds one FIFO word and presents it a byte at a time, MSB first.
// Partial words are left-justified on load so the same shift path serves both.
module cms_word_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic [2:0]  nbytes_i,
  input  logic        shift_i,
  output logic [7:0]  byte_o,
  output logic        last_o
);

  logic [31:0] sr_q, sr_d;
  logic [2:0]  cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      // Right-aligned partial word: its first byte sits at [8r-1:8r-8].
      case (nbytes_i)
        3'd1:    sr_d = {word_i[7:0],  24'h0};
        3'd2:    sr_d = {word_i[15:0], 16'h0};
        3'd3:    sr_d = {word_i[23:0], 8'h0};
        default: sr_d = word_i;
      endcase
      cnt_d = nbytes_i;
    end else if (shift_i && (cnt_q != 3'd0)) begin
      sr_d  = {sr_q[23:0], 8'h00};
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign byte_o = sr_q[31:24];
  assign last_o = (cnt_q == 3'd1);

endmodule

// File: rtl/cms_unpackage.sv
// Transmit side of the CMS byte packer: fetches 32-bit words from the host
// FIFO and streams them to the card as bytes under cs_o/cmd_code_o.
module cms_unpackage
  import cms_pkg::*;
#(
  parameter int START_HOLD_CYC = 3,
  parameter int TIMEOUT_CYC    = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      command_code_i,
  input  logic [7:0]      byte_numb_i,
  cms_unpackage_if.master bus,
  output logic [2:0]      cmd_code_o,
  output logic            cs_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            error_o
);

  localparam int HOLD_W = (START_HOLD_CYC > 1) ? $clog2(START_HOLD_CYC) : 1;
  localparam int TMO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(START_HOLD_CYC - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

  logic [2:0]        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [7:0]        rem_q, rem_d;
  logic [2:0]        cmd_q, cmd_d;
  logic              error_q, error_d;

  logic       load;
  logic       shift;
  logic       word_last;
  logic [7:0] shift_byte;

  cms_word_shifter u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load),
    .word_i   (bus.fifo_dout_i),
    .nbytes_i (word_bytes(rem_q)),
    .shift_i  (shift),
    .byte_o   (shift_byte),
    .last_o   (word_last)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = '0;
    tmo_d   = '0;
    rem_d   = rem_q;
    cmd_d   = cmd_q;
    error_d = error_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CMD;
          cmd_d   = command_code_i;
          rem_d   = byte_numb_i;
          error_d = 1'b0;
        end
      end
      S_CMD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = (rem_q == 8'd0) ? S_DONE : S_FETCH;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_FETCH: begin
        // A word arriving in the expiry cycle still gets read.
        if (!bus.fifo_empty_i) begin
          state_d = S_LOAD;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERROR;
          error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_LOAD: begin
        load    = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (bus.data_ready_i && (rem_q != 8'd0)) begin
          shift = 1'b1;
          rem_d = rem_q - 8'd1;
          if (word_last) begin
            state_d = (rem_q == 8'd1) ? S_DONE : S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      tmo_q   <= '0;
      rem_q   <= '0;
      cmd_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      tmo_q   <= tmo_d;
      rem_q   <= rem_d;
      cmd_q   <= cmd_d;
      error_q <= error_d;
    end
  end

  assign bus.fifo_rd_en_o = (state_q == S_FETCH) && !bus.fifo_empty_i;
  assign bus.data_valid_o = (state_q == S_SHIFT);
  assign bus.data_o       = bus.data_valid_o ? shift_byte : 8'h00;

  assign cs_o       = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign cmd_code_o = cs_o ? cmd_q : 3'd0;
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign error_o    = error_q;

endmodule

// File: tb/tb_cms_unpackage.sv
// Directed bench for cms_unpackage: a vector table of whole transfers plus
// hand-written sequences for stalls, FIFO timeout, reset abort and busy start.
module tb_cms_unpackage;
  import cms_pkg::*;

  typedef struct {
    string       name;
    logic [2:0]  cmd;
    logic [7:0]  n;
    int          nwords;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [63:0] exp;
    int          exp_reads;
    int          exp_first;
    int          exp_cycles;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       start_i;
  logic [2:0] cmd_in;
  logic [7:0] numb_in;
  logic [2:0] cmd_code_o;
  logic       cs_o, busy_o, done_o, error_o;

  cms_unpackage_if bus ();

  cms_unpackage #(.START_HOLD_CYC(3), .TIMEOUT_CYC(255)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .command_code_i (cmd_in),
    .byte_numb_i    (numb_in),
    .bus            (bus),
    .cmd_code_o     (cmd_code_o),
    .cs_o           (cs_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .error_o        (error_o)
  );

  initial clk = 1'b0;
  always #(CLK_PERIOD / 2) clk = ~clk;

  // Host FIFO model: registered read data, pointers never rewind.
  logic [31:0] fifo_mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign bus.fifo_empty_i = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (bus.fifo_rd_en_o && (rd_ptr != wr_ptr)) begin
      bus.fifo_dout_i <= fifo_mem[rd_ptr % 64];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Passive monitor, sampled mid-cycle; tests work on deltas of these totals.
  logic [7:0] got_q [$];
  int rd_total = 0, done_total = 0, valid_total = 0, cmd_bad = 0;
  int stall_total = 0, stall_bad = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [2:0] exp_cmd = 3'd0;

  always @(negedge clk) begin
    if (bus.data_valid_o && bus.data_ready_i) got_q.push_back(bus.data_o);
    if (bus.fifo_rd_en_o) rd_total++;
    if (done_o) done_total++;
    if (bus.data_valid_o) valid_total++;
    if (cs_o && (cmd_code_o != exp_cmd)) cmd_bad++;
    if (prev_stall) begin
      stall_total++;
      if (!bus.data_valid_o || (bus.data_o != prev_data)) stall_bad++;
    end
    prev_stall = bus.data_valid_o && !bus.data_ready_i;
    prev_data  = bus.data_o;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushWord(input logic [31:0] w);
    fifo_mem[wr_ptr % 64] = w;
    wr_ptr++;
  endtask

  // Start is sampled at the second posedge; the task returns just after it.
  task automatic startTransfer(input logic [2:0] cmd, input logic [7:0] n);
    @(posedge clk); #1;
    start_i = 1'b1;
    cmd_in  = cmd;
    numb_in = n;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // Runs one transfer; cycle c is the c-th negedge after start was sampled.
  task automatic applyStimulus(input logic [2:0] cmd, input logic [7:0] n,
                               input int budget, output int first_valid,
                               output logic cs1, output logic err1,
                               output int cycles);
    startTransfer(cmd, n);
    first_valid = -1;
    cs1 = 1'b0;
    err1 = 1'b1;
    cycles = budget;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cs1  = cs_o;
        err1 = error_o;
      end
      if (bus.data_valid_o && (first_valid < 0)) first_valid = c;
      if (!busy_o) begin
        cycles = c;
        break;
      end
    end
  endtask

  vec_t vecs [6];
  vec_t v;
  int   base, r0, d0, c0, v0, s0, sb0;
  int   fv, cyc, err_cycle, found;
  logic cs1, err1, cs_at_err, busy_at_err;
  logic [63:0] got;
  logic [4:0]  pat;

  task automatic collectBytes(input int from, output logic [63:0] packed_bytes);
    packed_bytes = '0;
    for (int b = from; (b < got_q.size()) && (b - from < 8); b++)
      packed_bytes[63 - 8 * (b - from) -: 8] = got_q[b];
  endtask

  initial begin
    vecs[0] = '{"n8_full",  3'd1, 8'd8, 2, 32'h11223344, 32'h55667788,
                64'h11223344_55667788, 2, 6, 17};
    vecs[1] = '{"n6_part2", 3'd2, 8'd6, 2, 32'hA1A2A3A4, 32'h0000B1B2,
                64'hA1A2A3A4_B1B20000, 2, 6, 15};
    vecs[2] = '{"n3_part3", 3'd3, 8'd3, 1, 32'hFFC1C2C3, 32'h0,
                64'hC1C2C300_00000000, 1, 6, 10};
    vecs[3] = '{"n1_part1", 3'd4, 8'd1, 1, 32'hEEEEEE5A, 32'h0,
                64'h5A000000_00000000, 1, 6, 8};
    vecs[4] = '{"n5_part1", 3'd7, 8'd5, 2, 32'h01020304, 32'h999999AB,
                64'h01020304_AB000000, 2, 6, 14};
    vecs[5] = '{"n0_empty", 3'd6, 8'd0, 0, 32'h0, 32'h0,
                64'h0, 0, -1, 5};

    rst_n   = 1'b0;
    start_i = 1'b0;
    cmd_in  = 3'd0;
    numb_in = 8'd0;
    bus.data_ready_i = 1'b1;

    #(CLK_PERIOD * 2 + 1);
    checkOutput("reset_outputs",
                {bus.fifo_rd_en_o, bus.data_o, bus.data_valid_o, cmd_code_o,
                 cs_o, busy_o, done_o, error_o}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_after_reset", {busy_o, cs_o, error_o}, 64'h0);

    $display("[TB] vector table");
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      exp_cmd = v.cmd;
      if (v.nwords > 0) pushWord(v.w0);
      if (v.nwords > 1) pushWord(v.w1);
      base = got_q.size(); r0 = rd_total; d0 = done_total; c0 = cmd_bad;
      applyStimulus(v.cmd, v.n, 60, fv, cs1, err1, cyc);
      collectBytes(base, got);
      checkOutput({v.name, ".bytes"}, got, v.exp);
      checkOutput({v.name, ".nbytes"}, 64'(got_q.size() - base), 64'(v.n));
      checkOutput({v.name, ".reads"}, 64'(rd_total - r0), 64'(v.exp_reads));
      checkOutput({v.name, ".done"}, 64'(done_total - d0), 64'd1);
      checkOutput({v.name, ".first_valid"}, 64'(fv), 64'(v.exp_first));
      checkOutput({v.name, ".cycles"}, 64'(cyc), 64'(v.exp_cycles));
      checkOutput({v.name, ".cs_cycle1"}, 64'(cs1), 64'd1);
      checkOutput({v.name, ".cmd_code"}, 64'(cmd_bad - c0), 64'd0);
    end

    $display("[TB] ready stalls 1-0-0-1-0-1");
    pushWord(32'hDEADBEEF);
    exp_cmd = 3'd3;
    base = got_q.size(); s0 = stall_total; sb0 = stall_bad; d0 = done_total;
    pat = 5'b00101;
    fork
      applyStimulus(3'd3, 8'd4, 60, fv, cs1, err1, cyc);
      begin
        for (int c = 0; (c < 40) && !bus.data_valid_o; c++) @(negedge clk);
        for (int k = 4; k >= 0; k--) begin
          @(posedge clk); #1;
          bus.data_ready_i = pat[k];
        end
        @(posedge clk); #1;
        bus.data_ready_i = 1'b1;
      end
    join
    collectBytes(base, got);
    checkOutput("stall.bytes", got, 64'hDEADBEEF_00000000);
    checkOutput("stall.nbytes", 64'(got_q.size() - base), 64'd4);
    checkOutput("stall.stall_cycles", 64'(stall_total - s0), 64'd3);
    checkOutput("stall.data_stable", 64'(stall_bad - sb0), 64'd0);
    checkOutput("stall.cycles", 64'(cyc), 64'd14);
    checkOutput("stall.done", 64'(done_total - d0), 64'd1);

    $display("[TB] empty FIFO timeout");
    exp_cmd = 3'd4;
    r0 = rd_total; v0 = valid_total; d0 = done_total;
    startTransfer(3'd4, 8'd4);
    err_cycle = -1; cs_at_err = 1'b1; busy_at_err = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (error_o && (err_cycle < 0)) begin
        err_cycle   = c;
        cs_at_err   = cs_o;
        busy_at_err = busy_o;
      end
      if (!busy_o) break;
    end
    checkOutput("timeout.err_cycle", 64'(err_cycle), 64'd259);
    checkOutput("timeout.cs_low", 64'(cs_at_err), 64'd0);
    checkOutput("timeout.busy_in_error", 64'(busy_at_err), 64'd1);
    checkOutput("timeout.idle", 64'(busy_o), 64'd0);
    checkOutput("timeout.no_valid", 64'(valid_total - v0), 64'd0);
    checkOutput("timeout.no_reads", 64'(rd_total - r0), 64'd0);
    checkOutput("timeout.no_done", 64'(done_total - d0), 64'd0);
    repeat (3) @(negedge clk);
    checkOutput("timeout.sticky", 64'(error_o), 64'd1);
    exp_cmd = 3'd0;
    applyStimulus(3'd0, 8'd0, 20, fv, cs1, err1, cyc);
    checkOutput("timeout.cleared_on_start", 64'(err1), 64'd0);
    checkOutput("timeout.cleared_after", 64'(error_o), 64'd0);

    $display("[TB] reset during third byte");
    pushWord(32'hCAFEF00D);
    exp_cmd = 3'd1;
    r0 = rd_total; d0 = done_total;
    startTransfer(3'd1, 8'd4);
    found = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (bus.data_valid_o && (bus.data_o == 8'hF0)) begin
        found = 1;
        break;
      end
    end
    checkOutput("rst.third_byte_seen", 64'(found), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst.async_outputs",
                {bus.fifo_rd_en_o, bus.data_o, bus.data_valid_o, cmd_code_o,
                 cs_o, busy_o, done_o, error_o}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst.no_done", 64'(done_total - d0), 64'd0);
    checkOutput("rst.one_read", 64'(rd_total - r0), 64'd1);
    exp_cmd = 3'd5;
    r0 = rd_total; d0 = done_total;
    applyStimulus(3'd5, 8'd0, 20, fv, cs1, err1, cyc);
    checkOutput("rst.n0_done", 64'(done_total - d0), 64'd1);
    checkOutput("rst.n0_no_read", 64'(rd_total - r0), 64'd0);
    checkOutput("rst.n0_cycles", 64'(cyc), 64'd5);

    $display("[TB] start while busy");
    pushWord(32'h10203040);
    pushWord(32'h50607080);
    exp_cmd = 3'd2;
    base = got_q.size(); c0 = cmd_bad; r0 = rd_total;
    fork
      applyStimulus(3'd2, 8'd8, 60, fv, cs1, err1, cyc);
      begin
        repeat (9) @(posedge clk);
        #1;
        start_i = 1'b1;
        cmd_in  = 3'd5;
        numb_in = 8'd2;
        @(posedge clk); #1;
        start_i = 1'b0;
      end
    join
    collectBytes(base, got);
    checkOutput("busy_start.bytes", got, 64'h10203040_50607080);
    checkOutput("busy_start.cmd_code", 64'(cmd_bad - c0), 64'd0);
    checkOutput("busy_start.reads", 64'(rd_total - r0), 64'd2);
    checkOutput("busy_start.cycles", 64'(cyc), 64'd17);
    repeat (3) @(negedge clk);
    checkOutput("busy_start.stays_idle", 64'(busy_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cms_unpackage.md
# cms_unpackage

Transmit-side counterpart of the CMS byte packer. It reads 32-bit words from a standard FIFO, splits them back into bytes in the packer's byte order, and drives them to the card-side byte interface with a valid/ready handshake. During the transfer it also drives the command code and chip select. It sits between the host-side word FIFO and the AD card command/data path.

## Interface
- START_HOLD_CYC, 3, cycles that cs_o/cmd_code_o are held before the first FIFO fetch (≥1)
- TIMEOUT_CYC, 255, consecutive empty-FIFO cycles in S_FETCH before error (≥1)
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- start_i  in  1  transfer request, sampled only in S_IDLE
- command_code_i  in  3  command, latched on accepted start
- byte_numb_i  in  8  bytes to send, latched on accepted start
- fifo_dout_i  in  32  FIFO read data, valid the cycle after fifo_rd_en_o
- fifo_empty_i  in  1  FIFO empty flag
- fifo_rd_en_o  out  1  FIFO read strobe
- data_o  out  8  byte to card
- data_valid_o  out  1  data_o valid
- data_ready_i  in  1  card accepts byte
- cmd_code_o  out  3  latched command while cs_o is high, else 0
- cs_o  out  1  transfer active (card select)
- busy_o  out  1  state ≠ S_IDLE
- done_o  out  1  one-cycle pulse, transfer complete
- error_o  out  1  sticky FIFO-underflow timeout flag

## Operation
- States:
  - S_IDLE → S_CMD on start_i.
  - S_CMD, START_HOLD_CYC cycles → S_FETCH, or → S_DONE if the latched count is 0.
  - S_FETCH → S_LOAD when !fifo_empty_i, or → S_ERROR when the timeout counter reaches TIMEOUT_CYC.
  - S_LOAD → S_SHIFT.
  - S_SHIFT → S_FETCH after the last byte of a word if remaining > 0, or → S_DONE if remaining = 0.
  - S_DONE → S_IDLE.
  - S_ERROR → S_IDLE.
- fifo_rd_en_o = (state==S_FETCH) && !fifo_empty_i. It is combinational and exactly one pulse per word.
- S_LOAD captures fifo_dout_i into the shift register and sets word_bytes = min(4, remaining). remaining is 8 bits and decrements once per accepted byte; it never wraps.
- Byte order:
  - Full word: MSB first, [31:24], [23:16], [15:8], [7:0].
  - Final partial word of r = N mod 4 bytes: right-aligned, first byte at [8r-1:8r-8] and last at [7:0]. Upper bytes are ignored.
- A byte is transferred on data_valid_o && data_ready_i. While valid && !ready, data_o holds stable.
- cs_o and cmd_code_o are high/driven from S_CMD through S_DONE inclusive. Both are 0 in S_IDLE and S_ERROR.
- The timeout counter clears on every FIFO read and on leaving S_FETCH.
- error_o sets on entering S_ERROR and clears on the next accepted start_i.
- start_i while busy_o is ignored; command and count are not re-latched.

## Timing
- Reset values: all outputs 0, state S_IDLE, counters 0. Reset mid-transfer aborts immediately, with no done_o and no fifo_rd_en_o.
- Start sampled at edge 0: cs_o is high from cycle 1, fifo_rd_en_o at cycle START_HOLD_CYC+1 (FIFO non-empty), first data_valid_o at cycle START_HOLD_CYC+3.
- Inter-word gap: 2 cycles (S_FETCH, S_LOAD). Sustained rate is 4 bytes per 6 cycles with ready held high.
- done_o pulses in the cycle after the last byte handshake. busy_o drops the cycle after that.
- An empty FIFO persisting through TIMEOUT_CYC cycles gives S_ERROR on the next cycle: error_o high, cs_o low. The block then returns to S_IDLE one cycle later.
- Simultaneous fifo_empty_i deassertion and timeout expiry: the read wins.

## Structure
- Shared package cms_pkg holds:
  - the state encoding localparams;
  - the CMS command code constants (3-bit);
  - CLK_PERIOD.
- One sub-module is natural: cms_word_shifter, which does the 32-bit load, the right-alignment select for partial words, and the byte-shift on handshake.

## Test plan
- N=8, FIFO 0x11223344, 0x55667788, ready=1 → bytes 11, 22, 33, 44, 55, 66, 77, 88; two fifo_rd_en_o pulses; done_o once; first valid at cycle 6.
- N=6, FIFO 0xA1A2A3A4, 0x0000B1B2 → A1, A2, A3, A4, B1, B2; upper 0x0000 never sent.
- N=4, data_ready_i toggled 1-0-0-1-0-1 → data_o stable while stalled, 4 bytes in order, no duplicates.
- N=4, FIFO empty for 255 cycles → error_o=1, cs_o=0, zero data_valid_o; next start clears error_o.
- rst_n low during the third byte → all outputs 0 asynchronously; after release, start with N=0 → done_o pulse with no fifo_rd_en_o.
- start_i pulsed mid-transfer with a different command → cmd_code_o and byte count unchanged.
